axi4_lite_master_sequencer: RTL
===============================

// Module: axi4_lite_master_sequencer
// PURPOSE
// - Shares one AXI4-Lite manager port among G_NB_REQ simple command requesters.
// - Round-robin arbitration; one transaction outstanding at a time.
// - Converts each accepted request into AW/W/B or AR/R channel sequences and returns the response to the winner.
// - Sits between in-fabric register clients and the AXI4-Lite interconnect/DUT slave.
// PARAMETERS
// - G_NB_REQ       2    number of requesters (>=1)
// - G_ADDR_WIDTH   32   AXI4-Lite address width
// - G_DATA_WIDTH   32   AXI4-Lite data width (32 or 64)
// - G_PROT         3'b000  constant driven on awprot/arprot
// PORTS
// - clk        in   1              system clock, rising edge
// - rst        in   1              asynchronous, active-high reset
// - req_valid  in   N              request pending, held stable until req_ready
// - req_wr     in   N              1 = write, 0 = read
// - req_addr   in   N*AW           request address, requester i at [i*AW +: AW]
// - req_wdata  in   N*DW           write data per requester
// - req_wstrb  in   N*DW/8         write strobes per requester
// - req_ready  out  N              one-cycle grant/accept pulse, one-hot
// - rsp_valid  out  N              one-cycle completion pulse to the owner, one-hot
// - rsp_rdata  out  DW             read data, shared; 0 after writes
// - rsp_resp   out  2              BRESP/RRESP of the completed transaction
// - busy       out  1              high from accept until rsp_valid inclusive
// - awvalid/awaddr[AW]/awprot[3]/awready, wvalid/wdata[DW]/wstrb[DW/8]/wready
// - bready/bvalid/bresp[2], arvalid/araddr[AW]/arprot[3]/arready, rready/rvalid/rdata[DW]/rresp[2]
// BEHAVIOUR
// - Reset (async, immediate): every output is 0; state IDLE; rr pointer = N-1, so requester 0 wins first.
// - All outputs are registered. No combinational path from AXI inputs to AXI outputs.
// - FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP.
// - IDLE: when any req_valid is high, grant the first requester after the rr pointer.
//   - Pulse req_ready[g]. Latch addr, data, strb and wr. Pointer <= g.
//   - Go to WR_ADDR_DATA or RD_ADDR. awvalid/wvalid or arvalid rises on cycle T+1.
// - WR_ADDR_DATA: awvalid and wvalid are asserted together.
//   - Each is dropped the cycle after its own handshake (valid&ready).
//   - Once both handshakes are done (same or different cycles), bready <= 1 and go to WR_RESP.
// - WR_RESP: on bvalid & bready, capture bresp, bready <= 0, go to RSP.
// - RD_ADDR: arvalid is held until arready, then arvalid <= 0, rready <= 1, go to RD_DATA.
// - RD_DATA: on rvalid & rready, capture rdata/rresp, rready <= 0, go to RSP.
// - RSP: rsp_valid[g] is high for exactly one cycle with rsp_rdata/rsp_resp valid, then IDLE.
//   - A new grant is possible on the cycle after RSP.
// - Minimum latency with zero-wait slave: req_ready at T, AXI valid T+1, rsp_valid T+4 (write and read).
// - AXI valid signals never drop before ready (AXI rule). Payload is stable while valid is high.
// - Requester drops req_valid before grant: no grant and no side effect.
// - Simultaneous requests: exactly one grant. A losing request stays pending and wins within N transactions.
// - rr wrap-around: the search goes from pointer+1 modulo N. With N=1 the arbiter degenerates to a fixed grant.
// - SLVERR/DECERR are passed through unchanged. No retry is performed.
// - Reset mid-transaction: the transaction is abandoned, no rsp_valid is issued, and the slave side must share the reset.
// STRUCTURE
// - axi4_lite_pkg:
//   - AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR constants.
//   - typedef enum t_axi4_lite_seq_state.
//   - C_AXI4_LITE_STRB_W function.
// - Sub-module axi4_lite_rr_arbiter (req N -> one-hot grant, pointer update on accept).
// - FSM, channel regs and capture regs stay in the top.
// TESTING
// - Single write from req0: addr 0x10, data 0xDEADBEEF, strb 0xF, zero-wait slave
//   -> one AW+W beat, rsp_valid[0] 4 cycles after req_ready, rsp_resp 00.
// - Read from req1: addr 0x10 after that write
//   -> araddr 0x10, rsp_rdata 0xDEADBEEF, rsp_valid[1] only.
// - All N=2 requesters held continuously for 6 transactions
//   -> grants alternate 0,1,0,1,0,1; never two req_ready in one cycle.
// - Slave with awready delayed 3 cycles and wready immediate
//   -> wvalid drops after 1 cycle, awvalid held 4 cycles, single B accepted.
// - Slave returns bresp 2'b10 on write to 0xFFC
//   -> rsp_resp 2'b10 to the owner, FSM back to IDLE, next request served.
// - rst asserted while in RD_DATA
//   -> all outputs 0 the same cycle, no rsp_valid, req0 granted first after release.

Source files
------------

// File: rtl/axi4_lite_master_sequencer_pkg.sv
// Shared definitions for the AXI4-Lite master sequencer.
// - AXI response codes.
// - Sequencer FSM state type.
// - Width helpers: strobe width and requester index width.
package axi4_lite_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR_DATA,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_RSP
    } t_axi4_lite_seq_state;

    // One strobe bit per data byte.
    function automatic int C_AXI4_LITE_STRB_W(input int dw);
        return dw / 8;
    endfunction

    // Index width that stays legal (>=1) when there is a single requester.
    function automatic int C_IDX_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi4_lite_master_sequencer_if.sv
// AXI4-Lite manager-side bus bundle.
// - master modport: driven by the sequencer (valids, payloads, bready/rready).
// - slave modport : driven by the subordinate (readies, B and R payloads).
interface axi4_lite_master_sequencer_if #(
    parameter int G_ADDR_WIDTH = 32,
    parameter int G_DATA_WIDTH = 32
);

    logic                        awvalid;
    logic [G_ADDR_WIDTH-1:0]     awaddr;
    logic [2:0]                  awprot;
    logic                        awready;
    logic                        wvalid;
    logic [G_DATA_WIDTH-1:0]     wdata;
    logic [G_DATA_WIDTH/8-1:0]   wstrb;
    logic                        wready;
    logic                        bready;
    logic                        bvalid;
    logic [1:0]                  bresp;
    logic                        arvalid;
    logic [G_ADDR_WIDTH-1:0]     araddr;
    logic [2:0]                  arprot;
    logic                        arready;
    logic                        rready;
    logic                        rvalid;
    logic [G_DATA_WIDTH-1:0]     rdata;
    logic [1:0]                  rresp;

    modport master (
        output awvalid, awaddr, awprot, input awready,
        output wvalid, wdata, wstrb,    input wready,
        output bready,                  input bvalid, bresp,
        output arvalid, araddr, arprot, input arready,
        output rready,                  input rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, output awready,
        input  wvalid, wdata, wstrb,    output wready,
        input  bready,                  output bvalid, bresp,
        input  arvalid, araddr, arprot, output arready,
        input  rready,                  output rvalid, rdata, rresp
    );

endinterface

// File: rtl/axi4_lite_master_sequencer_rr_arbiter.sv
// Round-robin arbiter.
// - req_i      : pending requests.
// - accept_i   : the consumer takes the current grant this cycle.
// - gnt_o      : one-hot grant (combinational from req_i and the pointer).
// - gnt_idx_o  : binary index of gnt_o.
// - any_o      : some request is pending.
// The search starts one past the last accepted index, so the pointer reset
// value of N-1 makes requester 0 the first winner.
module axi4_lite_rr_arbiter
    import axi4_lite_pkg::*;
#(
    parameter int G_NB_REQ = 2,
    parameter int G_IDX_W  = C_IDX_W(G_NB_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [G_NB_REQ-1:0] req_i,
    input  logic                accept_i,
    output logic [G_NB_REQ-1:0] gnt_o,
    output logic [G_IDX_W-1:0]  gnt_idx_o,
    output logic                any_o
);

    logic [G_IDX_W-1:0] ptr_q;
    logic [G_IDX_W-1:0] ptr_d;

    always_comb begin
        int idx;
        idx       = 0;
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        for (int k = 1; k <= G_NB_REQ; k++) begin
            idx = (int'(ptr_q) + k) % G_NB_REQ;
            if (!any_o && req_i[idx]) begin
                any_o      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = G_IDX_W'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept_i && any_o) begin
            ptr_d = gnt_idx_o;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= G_IDX_W'(G_NB_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/axi4_lite_master_sequencer.sv
// AXI4-Lite master sequencer: shares one AXI4-Lite manager port among
// G_NB_REQ command requesters, one transaction outstanding at a time.
// Ports:
// - clk, rst        : clock, asynchronous active-high reset.
// - req_valid/wr    : per-requester request and direction (1 = write).
// - req_addr/wdata/wstrb : per-requester payload, requester i in slice i.
// - req_ready       : one-cycle one-hot accept pulse.
// - rsp_valid       : one-cycle one-hot completion pulse to the owner.
// - rsp_rdata/resp  : shared completion data (0 after writes) and response.
// - busy            : accept through rsp_valid inclusive.
// - axi             : AXI4-Lite manager port.
// Every output is a flop; AXI inputs only reach outputs through registers.
module axi4_lite_master_sequencer
    import axi4_lite_pkg::*;
#(
    parameter int         G_NB_REQ     = 2,
    parameter int         G_ADDR_WIDTH = 32,
    parameter int         G_DATA_WIDTH = 32,
    parameter logic [2:0] G_PROT       = 3'b000
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [G_NB_REQ-1:0]                  req_valid,
    input  logic [G_NB_REQ-1:0]                  req_wr,
    input  logic [G_NB_REQ*G_ADDR_WIDTH-1:0]     req_addr,
    input  logic [G_NB_REQ*G_DATA_WIDTH-1:0]     req_wdata,
    input  logic [G_NB_REQ*(G_DATA_WIDTH/8)-1:0] req_wstrb,
    output logic [G_NB_REQ-1:0]                  req_ready,
    output logic [G_NB_REQ-1:0]                  rsp_valid,
    output logic [G_DATA_WIDTH-1:0]              rsp_rdata,
    output logic [1:0]                           rsp_resp,
    output logic                                 busy,
    axi4_lite_master_sequencer_if.master         axi
);

    localparam int SW = C_AXI4_LITE_STRB_W(G_DATA_WIDTH);
    localparam int IW = C_IDX_W(G_NB_REQ);

    t_axi4_lite_seq_state     state_q;
    logic [IW-1:0]            owner_q;
    logic [G_ADDR_WIDTH-1:0]  addr_q;
    logic [G_DATA_WIDTH-1:0]  wdata_q;
    logic [SW-1:0]            wstrb_q;
    logic                     awvalid_q;
    logic                     wvalid_q;
    logic                     aw_done_q;
    logic                     w_done_q;
    logic                     bready_q;
    logic                     arvalid_q;
    logic                     rready_q;
    logic [G_DATA_WIDTH-1:0]  rdata_q;
    logic [1:0]               resp_q;
    logic [G_NB_REQ-1:0]      req_ready_q;
    logic [G_NB_REQ-1:0]      rsp_valid_q;
    logic                     busy_q;

    logic [G_NB_REQ-1:0]      arb_gnt;
    logic [IW-1:0]            arb_idx;
    logic                     arb_any;
    logic [G_ADDR_WIDTH-1:0]  sel_addr;
    logic [G_DATA_WIDTH-1:0]  sel_wdata;
    logic [SW-1:0]            sel_wstrb;
    logic                     sel_wr;
    logic [G_NB_REQ-1:0]      owner_oh;
    logic                     aw_fin;
    logic                     w_fin;

    // Grants are only taken in IDLE, so the pointer only moves on an accept.
    axi4_lite_rr_arbiter #(
        .G_NB_REQ (G_NB_REQ),
        .G_IDX_W  (IW)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_valid),
        .accept_i  (state_q == S_IDLE),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx),
        .any_o     (arb_any)
    );

    assign sel_addr  = req_addr[int'(arb_idx)*G_ADDR_WIDTH +: G_ADDR_WIDTH];
    assign sel_wdata = req_wdata[int'(arb_idx)*G_DATA_WIDTH +: G_DATA_WIDTH];
    assign sel_wstrb = req_wstrb[int'(arb_idx)*SW +: SW];
    assign sel_wr    = req_wr[arb_idx];

    always_comb begin
        owner_oh = '0;
        for (int i = 0; i < G_NB_REQ; i++) begin
            owner_oh[i] = (owner_q == IW'(i));
        end
    end

    // A channel is finished if it already handshook or handshakes now; AW and
    // W may complete in either order or together.
    assign aw_fin = aw_done_q | (awvalid_q & axi.awready);
    assign w_fin  = w_done_q  | (wvalid_q  & axi.wready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rdata_q     <= '0;
            resp_q      <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    if (arb_any) begin
                        req_ready_q <= arb_gnt;
                        owner_q     <= arb_idx;
                        addr_q      <= sel_addr;
                        wdata_q     <= sel_wdata;
                        wstrb_q     <= sel_wstrb;
                        aw_done_q   <= 1'b0;
                        w_done_q    <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= sel_wr ? S_WR_ADDR_DATA : S_RD_ADDR;
                    end
                end
                S_WR_ADDR_DATA: begin
                    // First cycle here raises both valids; each falls right
                    // after its own handshake.
                    if (!aw_done_q) begin
                        if (awvalid_q && axi.awready) begin
                            awvalid_q <= 1'b0;
                            aw_done_q <= 1'b1;
                        end else begin
                            awvalid_q <= 1'b1;
                        end
                    end
                    if (!w_done_q) begin
                        if (wvalid_q && axi.wready) begin
                            wvalid_q <= 1'b0;
                            w_done_q <= 1'b1;
                        end else begin
                            wvalid_q <= 1'b1;
                        end
                    end
                    if (aw_fin && w_fin) begin
                        bready_q <= 1'b1;
                        state_q  <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (axi.bvalid && bready_q) begin
                        resp_q   <= axi.bresp;
                        rdata_q  <= '0;
                        bready_q <= 1'b0;
                        state_q  <= S_RSP;
                    end
                end
                S_RD_ADDR: begin
                    if (arvalid_q && axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_RD_DATA;
                    end else begin
                        arvalid_q <= 1'b1;
                    end
                end
                S_RD_DATA: begin
                    if (axi.rvalid && rready_q) begin
                        rdata_q  <= axi.rdata;
                        resp_q   <= axi.rresp;
                        rready_q <= 1'b0;
                        state_q  <= S_RSP;
                    end
                end
                S_RSP: begin
                    // busy stays high through the rsp_valid cycle; IDLE
                    // clears it unless it grants again straight away.
                    rsp_valid_q <= owner_oh;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_resp    = resp_q;
    assign busy        = busy_q;

    assign axi.awvalid = awvalid_q;
    assign axi.awaddr  = addr_q;
    assign axi.awprot  = G_PROT;
    assign axi.wvalid  = wvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.bready  = bready_q;
    assign axi.arvalid = arvalid_q;
    assign axi.araddr  = addr_q;
    assign axi.arprot  = G_PROT;
    assign axi.rready  = rready_q;

endmodule
